// File: rtl/bresenham_pkg.sv
// Shared types and constants for the Bresenham beam tracer.
package bresenham_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    EMIT,
    DONE
  } state_t;

  localparam logic CELL_OCCUPIED = 1'b0;
  localparam logic CELL_FREE     = 1'b1;

  // Headroom for |d| up to 2^W-1 plus the doubled error term, signed.
  function automatic int unsigned err_width(input int unsigned coord_w);
    return coord_w + 3;
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham walk step: next cursor/error from the current ones, plus origin detect.
module bresenham_step
  import bresenham_pkg::*;
#(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned ERR_W   = err_width(COORD_W)
) (
  input  logic [COORD_W-1:0]      cur_x,
  input  logic [COORD_W-1:0]      cur_y,
  input  logic [COORD_W-1:0]      org_x,
  input  logic [COORD_W-1:0]      org_y,
  input  logic signed [ERR_W-1:0] err,
  input  logic signed [ERR_W-1:0] dx,
  input  logic signed [ERR_W-1:0] dy,
  input  logic                    sx_pos,
  input  logic                    sy_pos,
  output logic [COORD_W-1:0]      nxt_x,
  output logic [COORD_W-1:0]      nxt_y,
  output logic signed [ERR_W-1:0] nxt_err,
  output logic                    at_origin
);

  logic signed [ERR_W-1:0] e2;

  always_comb begin
    e2      = err <<< 1;
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    nxt_err = err;
    if (e2 >= dy) begin
      nxt_err = nxt_err + dy;
      nxt_x   = sx_pos ? cur_x + COORD_W'(1) : cur_x - COORD_W'(1);
    end
    // Both branches use the pre-step e2, so a diagonal move applies both adds.
    if (e2 <= dx) begin
      nxt_err = nxt_err + dx;
      nxt_y   = sy_pos ? cur_y + COORD_W'(1) : cur_y - COORD_W'(1);
    end
    at_origin = (cur_x == org_x) && (cur_y == org_y);
  end

endmodule

// File: rtl/bresenham_line_engine.sv
// Traces a sensor beam from endpoint back to origin, streaming one grid cell per transfer.
module bresenham_line_engine
  import bresenham_pkg::*;
#(
  parameter int unsigned COORD_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] origin_x,
  input  logic [COORD_W-1:0] origin_y,
  input  logic [COORD_W-1:0] end_x,
  input  logic [COORD_W-1:0] end_y,
  input  logic               hit,
  output logic [COORD_W-1:0] cell_x,
  output logic [COORD_W-1:0] cell_y,
  output logic               cell_is_free,
  output logic               cell_valid,
  input  logic               cell_ready,
  output logic               busy,
  output logic               done
);

  localparam int unsigned ERR_W = err_width(COORD_W);

  state_t                  state_q, state_d;
  logic [COORD_W-1:0]      org_x_q, org_x_d, org_y_q, org_y_d;
  logic [COORD_W-1:0]      cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic signed [ERR_W-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d;
  logic                    sx_pos_q, sx_pos_d, sy_pos_q, sy_pos_d;
  logic                    hit_q, hit_d;
  logic                    cell_valid_q, cell_valid_d;
  logic                    cell_is_free_q, cell_is_free_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic [COORD_W-1:0]      nxt_x, nxt_y;
  logic signed [ERR_W-1:0] nxt_err;
  logic                    at_origin;

  logic signed [ERR_W-1:0] org_x_s, org_y_s, cur_x_s, cur_y_s, dx_abs, dy_abs;

  assign org_x_s = ERR_W'(org_x_q);
  assign org_y_s = ERR_W'(org_y_q);
  assign cur_x_s = ERR_W'(cur_x_q);
  assign cur_y_s = ERR_W'(cur_y_q);
  assign dx_abs  = (org_x_s > cur_x_s) ? org_x_s - cur_x_s : cur_x_s - org_x_s;
  assign dy_abs  = (org_y_s > cur_y_s) ? org_y_s - cur_y_s : cur_y_s - org_y_s;

  bresenham_step #(
    .COORD_W(COORD_W),
    .ERR_W  (ERR_W)
  ) u_step (
    .cur_x    (cur_x_q),
    .cur_y    (cur_y_q),
    .org_x    (org_x_q),
    .org_y    (org_y_q),
    .err      (err_q),
    .dx       (dx_q),
    .dy       (dy_q),
    .sx_pos   (sx_pos_q),
    .sy_pos   (sy_pos_q),
    .nxt_x    (nxt_x),
    .nxt_y    (nxt_y),
    .nxt_err  (nxt_err),
    .at_origin(at_origin)
  );

  always_comb begin
    state_d        = state_q;
    org_x_d        = org_x_q;
    org_y_d        = org_y_q;
    cur_x_d        = cur_x_q;
    cur_y_d        = cur_y_q;
    err_d          = err_q;
    dx_d           = dx_q;
    dy_d           = dy_q;
    sx_pos_d       = sx_pos_q;
    sy_pos_d       = sy_pos_q;
    hit_d          = hit_q;
    cell_valid_d   = cell_valid_q;
    cell_is_free_d = cell_is_free_q;
    done_d         = 1'b0;
    busy_d         = busy_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          busy_d  = 1'b1;
          org_x_d = origin_x;
          org_y_d = origin_y;
          cur_x_d = end_x;
          cur_y_d = end_y;
          hit_d   = hit;
        end
      end
      SETUP: begin
        // The cursor already holds the endpoint; steps head back toward the origin.
        state_d        = EMIT;
        dx_d           = dx_abs;
        dy_d           = -dy_abs;
        err_d          = dx_abs - dy_abs;
        sx_pos_d       = org_x_q > cur_x_q;
        sy_pos_d       = org_y_q > cur_y_q;
        cell_valid_d   = 1'b1;
        cell_is_free_d = hit_q ? CELL_OCCUPIED : CELL_FREE;
      end
      EMIT: begin
        if (cell_valid_q && cell_ready) begin
          if (at_origin) begin
            state_d      = DONE;
            cell_valid_d = 1'b0;
            done_d       = 1'b1;
          end else begin
            cur_x_d        = nxt_x;
            cur_y_d        = nxt_y;
            err_d          = nxt_err;
            cell_is_free_d = CELL_FREE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      cell_valid_d = 1'b0;
      done_d       = 1'b0;
      busy_d       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      org_x_q        <= '0;
      org_y_q        <= '0;
      cur_x_q        <= '0;
      cur_y_q        <= '0;
      err_q          <= '0;
      dx_q           <= '0;
      dy_q           <= '0;
      sx_pos_q       <= 1'b0;
      sy_pos_q       <= 1'b0;
      hit_q          <= 1'b0;
      cell_valid_q   <= 1'b0;
      cell_is_free_q <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      org_x_q        <= org_x_d;
      org_y_q        <= org_y_d;
      cur_x_q        <= cur_x_d;
      cur_y_q        <= cur_y_d;
      err_q          <= err_d;
      dx_q           <= dx_d;
      dy_q           <= dy_d;
      sx_pos_q       <= sx_pos_d;
      sy_pos_q       <= sy_pos_d;
      hit_q          <= hit_d;
      cell_valid_q   <= cell_valid_d;
      cell_is_free_q <= cell_is_free_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
    end
  end

  assign cell_x       = cur_x_q;
  assign cell_y       = cur_y_q;
  assign cell_is_free = cell_is_free_q;
  assign cell_valid   = cell_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Checks the beam tracer (8-bit and 4-bit builds) against a line-walk reference model.
module tb_bresenham_line_engine;

  logic       clock = 1'b0;
  logic       reset, start, abort, hit, cell_ready, sel;
  logic [7:0] origin_x, origin_y, end_x, end_y;

  logic [7:0] x8, y8;
  logic [3:0] x4, y4;
  logic       free8, free4, v8, v4, busy8, busy4, done8, done4;
  logic [7:0] cx, cy;
  logic       cfree, cv, cbusy, cdone;

  always #5 clock = ~clock;

  bresenham_line_engine #(.COORD_W(8)) dut8 (
    .clock(clock), .reset(reset), .start(start & ~sel), .abort(abort),
    .origin_x(origin_x), .origin_y(origin_y), .end_x(end_x), .end_y(end_y),
    .hit(hit), .cell_x(x8), .cell_y(y8), .cell_is_free(free8),
    .cell_valid(v8), .cell_ready(cell_ready), .busy(busy8), .done(done8)
  );

  bresenham_line_engine #(.COORD_W(4)) dut4 (
    .clock(clock), .reset(reset), .start(start & sel), .abort(abort),
    .origin_x(origin_x[3:0]), .origin_y(origin_y[3:0]),
    .end_x(end_x[3:0]), .end_y(end_y[3:0]),
    .hit(hit), .cell_x(x4), .cell_y(y4), .cell_is_free(free4),
    .cell_valid(v4), .cell_ready(cell_ready), .busy(busy4), .done(done4)
  );

  assign cx    = sel ? {4'b0, x4} : x8;
  assign cy    = sel ? {4'b0, y4} : y8;
  assign cfree = sel ? free4 : free8;
  assign cv    = sel ? v4 : v8;
  assign cbusy = sel ? busy4 : busy8;
  assign cdone = sel ? done4 : done8;

  int errors = 0;
  int checks = 0;
  int exp_x[$];
  int exp_y[$];
  bit exp_f[$];

  typedef struct {
    int ox, oy, ex, ey;
    bit hit;
    bit w4;
    int n;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Walk the line endpoint -> origin with integer Bresenham, recording each cell.
  function automatic void build_ref(input int ox, oy, ex, ey, input bit h);
    int x, y, dx, dy, sx, sy, err, e2;
    exp_x.delete(); exp_y.delete(); exp_f.delete();
    x = ex; y = ey;
    dx = iabs(ex - ox); dy = -iabs(ey - oy);
    sx = (ox > ex) ? 1 : -1;
    sy = (oy > ey) ? 1 : -1;
    err = dx + dy;
    for (int k = 0; k < 1000; k++) begin
      exp_x.push_back(x);
      exp_y.push_back(y);
      exp_f.push_back((k == 0) ? !h : 1'b1);
      if (x == ox && y == oy) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  // rmode: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random ready.
  task automatic run_beam(input int ox, oy, ex, ey, input bit h, input bit w4,
                          input int rmode, input bit poke, input int exp_n);
    int got, px, py;
    bit stalled, dn, rdy;
    logic [7:0] hx, hy;
    logic hf;
    build_ref(ox, oy, ex, ey, h);
    sel = w4;
    origin_x = 8'(ox); origin_y = 8'(oy);
    end_x = 8'(ex); end_y = 8'(ey);
    hit = h; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("setup_busy", 32'(cbusy), 1);
    check("setup_valid", 32'(cv), 0);
    got = 0; stalled = 0; dn = 0; px = 0; py = 0; hx = '0; hy = '0; hf = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      if (poke && c == 1) begin
        start = 1'b1; origin_x = 8'($urandom); end_x = 8'($urandom); hit = ~h;
      end else if (poke && c == 2) begin
        start = 1'b0;
      end
      if (cdone) begin dn = 1; break; end
      if (!cv) begin check("valid_held", 32'(cv), 1); break; end
      if (stalled) check("stall_stable", {15'd0, cx, cy, cfree}, {15'd0, hx, hy, hf});
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = (c % 3 == 0);
        default: rdy = ($urandom % 4 != 0);
      endcase
      cell_ready = rdy;
      if (rdy) begin
        if (got < exp_x.size())
          check("cell", {15'd0, cx, cy, cfree},
                {15'd0, 8'(exp_x[got]), 8'(exp_y[got]), exp_f[got]});
        else
          check("extra_cell", 32'(got), 32'(exp_x.size()));
        if (got > 0)
          check("step_size", 32'(iabs(int'(cx) - px) <= 1 && iabs(int'(cy) - py) <= 1), 1);
        px = int'(cx); py = int'(cy);
        got++;
        stalled = 0;
      end else begin
        stalled = 1; hx = cx; hy = cy; hf = cfree;
      end
    end
    cell_ready = 1'b0;
    check("done_seen", 32'(dn), 1);
    check("cell_count", 32'(got), 32'(exp_n));
    @(negedge clock);
    check("done_one_cycle", 32'(cdone), 0);
    check("idle_busy", 32'(cbusy), 0);
  endtask

  initial begin
    int n, rox, roy, rex, rey;
    reset = 1'b1; start = 1'b0; abort = 1'b0; hit = 1'b0; cell_ready = 1'b0; sel = 1'b0;
    origin_x = '0; origin_y = '0; end_x = '0; end_y = '0;

    vecs[0] = '{10, 10, 14, 12, 1'b1, 1'b0, 5};
    vecs[1] = '{10, 10, 12, 14, 1'b1, 1'b0, 5};
    vecs[2] = '{10, 10,  6, 13, 1'b1, 1'b0, 5};
    vecs[3] = '{10, 10,  7,  5, 1'b1, 1'b0, 6};
    vecs[4] = '{10, 10, 13,  6, 1'b1, 1'b0, 5};
    vecs[5] = '{ 3,  3,  3,  3, 1'b1, 1'b0, 1};
    vecs[6] = '{ 3,  3,  3,  3, 1'b0, 1'b0, 1};
    vecs[7] = '{ 0,  0, 15, 15, 1'b1, 1'b1, 16};
    vecs[8] = '{15,  0,  0, 15, 1'b0, 1'b1, 16};

    repeat (3) @(negedge clock);
    check("reset_outputs8", {12'd0, v8, done8, busy8, free8, x8, y8}, 0);
    check("reset_outputs4", {20'd0, v4, done4, busy4, free4, x4, y4}, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 9; i++)
      run_beam(vecs[i].ox, vecs[i].oy, vecs[i].ex, vecs[i].ey, vecs[i].hit, vecs[i].w4,
               0, 1'b0, vecs[i].n);

    run_beam(0, 0, 5, 2, 1'b1, 1'b0, 1, 1'b0, 6);
    run_beam(10, 20, 40, 30, 1'b0, 1'b0, 0, 1'b1, 31);

    for (int i = 0; i < 20; i++) begin
      rox = $urandom % 256; roy = $urandom % 256;
      rex = $urandom % 256; rey = $urandom % 256;
      n = (iabs(rex - rox) > iabs(rey - roy)) ? iabs(rex - rox) : iabs(rey - roy);
      run_beam(rox, roy, rex, rey, 1'($urandom), 1'b0, 2, 1'b0, n + 1);
    end

    // Abort on the third presented cell.
    sel = 1'b0; origin_x = 0; origin_y = 0; end_x = 20; end_y = 0; hit = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0; cell_ready = 1'b1; n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (cv) n++;
      if (n == 3) begin abort = 1'b1; break; end
    end
    check("abort_reached", 32'(n), 3);
    @(negedge clock);
    abort = 1'b0; cell_ready = 1'b0;
    check("abort_idle", {29'd0, cv, cbusy, cdone}, 0);
    run_beam(0, 0, 7, 3, 1'b1, 1'b0, 0, 1'b0, 8);

    // Reset on the fourth presented cell.
    origin_x = 0; origin_y = 0; end_x = 20; end_y = 5; hit = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0; cell_ready = 1'b1; n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (cv) n++;
      if (n == 4) begin reset = 1'b1; break; end
    end
    check("reset_reached", 32'(n), 4);
    @(negedge clock);
    reset = 1'b0; cell_ready = 1'b0;
    check("reset_mid_beam", {12'd0, cv, cdone, cbusy, cfree, cx, cy}, 0);
    run_beam(2, 9, 9, 2, 1'b0, 1'b0, 2, 1'b0, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
